// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// seven_seg_scan_mux : double-buffered time-multiplexed BCD scan driver for a
//                      seven-segment decoder; optional SEVEN_SEG_LZ_BLANK_EN
//                      enables leading-zero blanking of the digit enables.
// Revision: 1.0
// ============================================================================
module seven_seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_in_i,
  output logic [3:0]              bcd_o,
  output logic [NUM_DIGITS-1:0]   digit_en_o,
  output logic                    frame_start_o,
  output logic                    busy_o
);

  localparam int c_DW    = 4 * NUM_DIGITS;
  localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic [c_IDX_W-1:0]    idx_q, idx_d;
  logic [c_DW-1:0]       disp_q, disp_d;
  logic [c_DW-1:0]       pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fs_q, fs_d;

  logic                  w_slot_tick;
  logic                  w_frame_tick;
  logic [NUM_DIGITS-1:0] w_upper_nz;

  assign w_slot_tick  = (cnt_q == c_CNT_LAST);
  assign w_frame_tick = w_slot_tick && (idx_q == c_IDX_LAST);

  // w_upper_nz[k]: some committed digit at position k or above is non-zero
`ifdef SEVEN_SEG_LZ_BLANK_EN
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz_blank
    assign w_upper_nz[k] = |disp_d[c_DW-1:4*k];
  end
`else
  assign w_upper_nz = '1;
`endif

  always_comb begin
    cnt_d    = w_slot_tick ? '0 : cnt_q + c_CNT_W'(1);
    idx_d    = idx_q;
    if (w_slot_tick) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_W'(1);
    end

    // Commit uses the old pending value; a coincident load refills pend
    disp_d   = (w_frame_tick && pend_v_q) ? pend_q : disp_q;
    pend_d   = load_i ? digits_in_i : pend_q;
    pend_v_d = load_i ? 1'b1 : (w_frame_tick ? 1'b0 : pend_v_q);

    bcd_d = 4'h0;
    en_d  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == c_IDX_W'(k)) begin
        bcd_d   = disp_d[4*k +: 4];
        en_d[k] = (k == 0) || w_upper_nz[k];
      end
    end
    fs_d = w_frame_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      bcd_q    <= 4'h0;
      en_q     <= NUM_DIGITS'(1);
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      bcd_q    <= bcd_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign digit_en_o    = en_q;
  assign frame_start_o = fs_q;
  assign busy_o        = pend_v_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_scan_mux : scoreboard bench for seven_seg_scan_mux (4 digits,
//                         4-cycle slots). Revision: 1.0
// ============================================================================
module tb_seven_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] digits_in_i = 16'h0;
  logic [3:0]  bcd_o;
  logic [3:0]  digit_en_o;
  logic        frame_start_o;
  logic        busy_o;

  seven_seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_i),
    .digits_in_i   (digits_in_i),
    .bcd_o         (bcd_o),
    .digit_en_o    (digit_en_o),
    .frame_start_o (frame_start_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state and expected-output queue
  int          m_cnt  = 0;
  int          m_idx  = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_pv   = 1'b0;
  logic        m_fs   = 1'b0;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // Packing: [9:6] bcd, [5:2] digit_en, [1] frame_start, [0] busy
  function automatic logic [15:0] model_out();
    logic [15:0] sh;
    logic [3:0]  en;
    sh = m_disp >> (4 * m_idx);
    en = 4'b0001 << m_idx;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (m_idx > 0 && sh == 16'h0) en = 4'b0000;
`endif
    return {6'b0, sh[3:0], en, m_fs, m_pv};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0; m_fs = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    logic tick, ftick;
    logic [15:0] e;
    load_i      = ld;
    digits_in_i = d;
    tick  = (m_cnt == RD - 1);
    ftick = tick && (m_idx == ND - 1);
    if (ftick && m_pv) m_disp = m_pend;
    if (ftick) m_pv = 1'b0;
    if (ld) begin m_pend = d; m_pv = 1'b1; end
    if (tick) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
    else m_cnt++;
    m_fs = ftick;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    load_i = 1'b0;
    e = sb.pop_front();
    chk("cycle", 16'({bcd_o, digit_en_o, frame_start_o, busy_o}), e);
  endtask

  // Records bcd/enable at the first cycle of each slot of one frame
  task automatic capture(output logic [15:0] bcds, output logic [15:0] ens);
    bcds = 16'h0;
    ens  = 16'h0;
    for (int s = 0; s < ND * RD; s++) begin
      if (s % RD == 0) begin
        bcds[4*(s/RD) +: 4] = bcd_o;
        ens[4*(s/RD) +: 4]  = digit_en_o;
      end
      step(1'b0, 16'h0);
    end
  endtask

  task automatic run_to_frame();
    int n;
    n = 0;
    do begin
      step(1'b0, 16'h0);
      n++;
    end while (!frame_start_o && n < 64);
    chk("frame_wait", 16'(frame_start_o), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] bcds, ens;
    #1 rst = 1'b1;
    #1;
    chk("reset_out", 16'({bcd_o, digit_en_o, frame_start_o, busy_o}),
        16'({4'h0, 4'b0001, 1'b0, 1'b0}));
    @(negedge clk) rst = 1'b0;
    model_reset();

    // Idle frame after reset
    capture(bcds, ens);
    chk("idle_bcd", bcds, 16'h0000);
    chk("idle_en", ens, 16'h8421);
    chk("idle_fs16", 16'(frame_start_o), 16'd1);

    // Single load mid-frame
    step(1'b0, 16'h0);
    step(1'b1, 16'h1234);
    chk("busy_after_load", 16'(busy_o), 16'd1);
    run_to_frame();
    chk("busy_after_commit", 16'(busy_o), 16'd0);
    capture(bcds, ens);
    chk("frame_1234", bcds, 16'h1234);

    // Two loads in one frame: last wins
    step(1'b1, 16'h1111);
    step(1'b0, 16'h0);
    step(1'b1, 16'h9876);
    run_to_frame();
    capture(bcds, ens);
    chk("frame_9876", bcds, 16'h9876);

    // Load on the boundary edge that commits a pending value
    step(1'b1, 16'h2222);
    while (!(m_cnt == RD - 1 && m_idx == ND - 1)) step(1'b0, 16'h0);
    step(1'b1, 16'h5555);
    chk("bnd_fs", 16'(frame_start_o), 16'd1);
    chk("bnd_busy", 16'(busy_o), 16'd1);
    capture(bcds, ens);
    chk("frame_2222", bcds, 16'h2222);
    chk("busy_after_5555", 16'(busy_o), 16'd0);
    capture(bcds, ens);
    chk("frame_5555", bcds, 16'h5555);

    // Random soak against the model
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 3) == 0), 16'($urandom));

    // Asynchronous reset mid-slot with a pending value
    step(1'b1, 16'hAAAA);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 16'({bcd_o, digit_en_o, frame_start_o, busy_o}),
        16'({4'h0, 4'b0001, 1'b0, 1'b0}));
    model_reset();
    @(negedge clk) rst = 1'b0;
    capture(bcds, ens);
    chk("post_rst_bcd", bcds, 16'h0000);
    capture(bcds, ens);
    chk("post_rst_discard", bcds, 16'h0000);
    chk("post_rst_en", ens, 16'h8421);

    // Leading-zero pattern
    step(1'b1, 16'h0042);
    run_to_frame();
    capture(bcds, ens);
    chk("lz_bcd", bcds, 16'h0042);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    chk("lz_en", ens, 16'h0021);
`else
    chk("lz_en", ens, 16'h8421);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
